// File: rtl/univ_reg_fall_syn_pkg.sv
// -----------------------------------------------------------------------------
// univ_reg_fall_syn_pkg
// Shared definitions for the universal falling-edge register and the labs that
// reuse its operation encoding (shifter, counter, accumulator).
//   mode_e : 3-bit operation select, MODE_HOLD .. MODE_DOWN
//   is_shift_mode() : true for the four modes that move a bit out on ser_out
// -----------------------------------------------------------------------------
package univ_reg_fall_syn_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

  // Shift and rotate modes are the only ones that update ser_out.
  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage : univ_reg_fall_syn_pkg

// File: rtl/univ_reg_fall_syn_bit.sv
// -----------------------------------------------------------------------------
// dff_fall_syn_bit
// One-bit D flip-flop clocked on the falling edge of clk with a synchronous,
// active-high reset and a per-instance reset value.
//   clk    in  1  clock, state changes on the falling edge only
//   reset  in  1  synchronous active-high reset, loads RST_VAL
//   d      in  1  next-state data
//   q      out 1  stored bit
//   q_bar  out 1  complement of q
// -----------------------------------------------------------------------------
module dff_fall_syn_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_bar
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that existed before the edge, regardless of process order.
  always_ff @(negedge clk) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule : dff_fall_syn_bit

// File: rtl/univ_reg_fall_syn.sv
// -----------------------------------------------------------------------------
// univ_reg_fall_syn
// WIDTH-bit universal register built from falling-edge DFFs sharing one clock
// and one synchronous active-high reset. Per edge: reset > en=0 hold > mode.
//   clk       in  1      clock, falling-edge active
//   reset     in  1      synchronous active-high reset (q=RST_VAL, ser_out=0, tc=0)
//   en        in  1      1 = perform mode operation, 0 = hold (tc forced low)
//   mode      in  3      operation select, see mode_e
//   d         in  WIDTH  parallel load data
//   ser_in_l  in  1      bit entering bit 0 on shift left
//   ser_in_r  in  1      bit entering bit WIDTH-1 on shift right
//   q         out WIDTH  register state
//   q_bar     out WIDTH  complement of q
//   ser_out   out 1      bit shifted/rotated out by the last shift or rotate
//   tc        out 1      high for one period after an UP or DOWN wrap
// -----------------------------------------------------------------------------
module univ_reg_fall_syn
  import univ_reg_fall_syn_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             ser_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  if (WIDTH < 2) begin : g_width_check
    $error("univ_reg_fall_syn: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_d;
  logic             ser_out_d;
  logic             tc_d;
  mode_e            op;

  // Reset is applied inside each flop, so this mux only covers hold vs. mode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    q_d       = q;
    ser_out_d = ser_out;
    tc_d      = 1'b0;
    op        = mode_e'(mode);
    if (en) begin
      case (op)
        MODE_HOLD: q_d = q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q[WIDTH-2:0], ser_in_l};
        MODE_SHR:  q_d = {ser_in_r, q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_d = {q[0], q[WIDTH-1:1]};
        MODE_UP: begin
          q_d  = q + ONE;
          tc_d = (q == ALL_ONES);
        end
        MODE_DOWN: begin
          q_d  = q - ONE;
          tc_d = (q == ALL_ZERO);
        end
        default: q_d = q;
      endcase
      // Left-moving ops expose the old MSB, right-moving ops the old LSB.
      if (is_shift_mode(op)) begin
        ser_out_d = ((op == MODE_SHL) || (op == MODE_ROL)) ? q[WIDTH-1] : q[0];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_fall_syn_bit #(
      .RST_VAL (RST_VAL[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (q_d[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  logic ser_out_bar_unused;
  logic tc_bar_unused;

  dff_fall_syn_bit #(
    .RST_VAL (1'b0)
  ) u_ser_out (
    .clk   (clk),
    .reset (reset),
    .d     (ser_out_d),
    .q     (ser_out),
    .q_bar (ser_out_bar_unused)
  );

  dff_fall_syn_bit #(
    .RST_VAL (1'b0)
  ) u_tc (
    .clk   (clk),
    .reset (reset),
    .d     (tc_d),
    .q     (tc),
    .q_bar (tc_bar_unused)
  );

endmodule : univ_reg_fall_syn

// File: tb/tb_univ_reg_fall_syn.sv
// -----------------------------------------------------------------------------
// tb_univ_reg_fall_syn
// Drives two instances (WIDTH=8/RST_VAL=0 and WIDTH=4/RST_VAL=9) from vector
// tables plus counting sequences. Inputs change on the rising edge, the DUT
// acts on the falling edge, and outputs are compared 1 ns after that edge
// against expectations queued when the stimulus was applied.
// -----------------------------------------------------------------------------
module tb_univ_reg_fall_syn;
  import univ_reg_fall_syn_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    mode_e      mode;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic [7:0] exp_q;
    logic       exp_so;
    logic       exp_tc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8, en8, sil8, sir8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, qb8;
  logic       so8, tc8;

  // 4-bit instance
  logic       rst4, en4, sil4, sir4;
  logic [2:0] mode4;
  logic [3:0] d4, q4, qb4;
  logic       so4, tc4;

  univ_reg_fall_syn #(.WIDTH(8), .RST_VAL(8'h00)) u_dut8 (
    .clk(clk), .reset(rst8), .en(en8), .mode(mode8), .d(d8),
    .ser_in_l(sil8), .ser_in_r(sir8),
    .q(q8), .q_bar(qb8), .ser_out(so8), .tc(tc8)
  );

  univ_reg_fall_syn #(.WIDTH(4), .RST_VAL(4'h9)) u_dut4 (
    .clk(clk), .reset(rst4), .en(en4), .mode(mode4), .d(d4),
    .ser_in_l(sil4), .ser_in_r(sir4),
    .q(q4), .q_bar(qb4), .ser_out(so4), .tc(tc4)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb8[$];
  vec_t sb4[$];
  vec_t t8[$];
  vec_t t4[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input mode_e m,
                              input logic [7:0] d, input logic sil, input logic sir,
                              input logic [7:0] eq, input logic eso, input logic etc);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = m; v.d = d; v.sil = sil; v.sir = sir;
    v.exp_q = eq; v.exp_so = eso; v.exp_tc = etc;
    return v;
  endfunction

  // Apply one vector to the selected instance and compare after the falling edge.
  task automatic run_vec(input bit four, input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    if (four) begin
      rst4 = v.rst; en4 = v.en; mode4 = v.mode; d4 = v.d[3:0]; sil4 = v.sil; sir4 = v.sir;
      sb4.push_back(v);
    end else begin
      rst8 = v.rst; en8 = v.en; mode8 = v.mode; d8 = v.d; sil8 = v.sil; sir8 = v.sir;
      sb8.push_back(v);
    end
    @(negedge clk);
    #1;
    if (four) begin
      e = sb4.pop_front();
      check({tag, " q"},       {4'h0, q4},  {4'h0, e.exp_q[3:0]});
      check({tag, " q_bar"},   {4'h0, qb4}, {4'h0, ~e.exp_q[3:0]});
      check({tag, " ser_out"}, {7'h0, so4}, {7'h0, e.exp_so});
      check({tag, " tc"},      {7'h0, tc4}, {7'h0, e.exp_tc});
    end else begin
      e = sb8.pop_front();
      check({tag, " q"},       q8,          e.exp_q);
      check({tag, " q_bar"},   qb8,         ~e.exp_q);
      check({tag, " ser_out"}, {7'h0, so8}, {7'h0, e.exp_so});
      check({tag, " tc"},      {7'h0, tc8}, {7'h0, e.exp_tc});
    end
  endtask

  initial begin
    rst8 = 1'b1; en8 = 1'b0; mode8 = 3'b000; d8 = 8'h00; sil8 = 1'b0; sir8 = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; mode4 = 3'b000; d4 = 4'h0; sil4 = 1'b0; sir4 = 1'b0;

    //                rst en mode       d      sil sir exp_q  so tc
    t8.push_back(mk(1, 1, MODE_LOAD, 8'h3C, 0, 0, 8'h00, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0));
    t8.push_back(mk(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h4B, 1, 0));
    t8.push_back(mk(0, 1, MODE_SHR,  8'h00, 0, 0, 8'h25, 1, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h01, 0, 0, 8'h01, 1, 0));
    t8.push_back(mk(0, 1, MODE_ROR,  8'h00, 0, 0, 8'h80, 1, 0));
    t8.push_back(mk(0, 1, MODE_ROL,  8'h00, 0, 0, 8'h01, 1, 0));
    t8.push_back(mk(0, 1, MODE_HOLD, 8'h77, 1, 1, 8'h01, 1, 0));
    t8.push_back(mk(0, 1, MODE_SHL,  8'h00, 0, 0, 8'h02, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0, 0));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'hFF, 0, 0));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h00, 0, 1));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h01, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0));
    t8.push_back(mk(0, 1, MODE_DOWN, 8'h00, 0, 0, 8'hFF, 0, 1));
    t8.push_back(mk(0, 0, MODE_DOWN, 8'h00, 0, 0, 8'hFF, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h10, 0, 0, 8'h10, 0, 0));
    for (int i = 0; i < 4; i++)
      t8.push_back(mk(0, 0, MODE_UP, 8'h00, 0, 0, 8'h10, 0, 0));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h11, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    t8.push_back(mk(0, 1, MODE_ROR,  8'h00, 0, 0, 8'hC0, 1, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'h7F, 0, 0, 8'h7F, 1, 0));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h80, 1, 0));
    t8.push_back(mk(1, 1, MODE_UP,   8'h00, 0, 0, 8'h00, 0, 0));
    t8.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h01, 0, 0));
    t8.push_back(mk(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0));
    t8.push_back(mk(1, 1, MODE_UP,   8'h00, 0, 0, 8'h00, 0, 0));
    t8.push_back(mk(0, 1, MODE_DOWN, 8'h00, 0, 0, 8'hFF, 0, 1));
    t8.push_back(mk(1, 1, MODE_DOWN, 8'h00, 0, 0, 8'h00, 0, 0));

    t4.push_back(mk(1, 1, MODE_LOAD, 8'h0C, 0, 0, 8'h09, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h0A, 0, 0, 8'h0A, 0, 0));
    t4.push_back(mk(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h05, 1, 0));
    t4.push_back(mk(0, 1, MODE_SHR,  8'h00, 0, 0, 8'h02, 1, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h01, 0, 0, 8'h01, 1, 0));
    t4.push_back(mk(0, 1, MODE_ROR,  8'h00, 0, 0, 8'h08, 1, 0));
    t4.push_back(mk(0, 1, MODE_ROL,  8'h00, 0, 0, 8'h01, 1, 0));
    t4.push_back(mk(0, 1, MODE_SHL,  8'h00, 0, 0, 8'h02, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h0E, 0, 0, 8'h0E, 0, 0));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h0F, 0, 0));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h00, 0, 1));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h01, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0));
    t4.push_back(mk(0, 1, MODE_DOWN, 8'h00, 0, 0, 8'h0F, 0, 1));
    t4.push_back(mk(0, 0, MODE_DOWN, 8'h00, 0, 0, 8'h0F, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h0F, 0, 0, 8'h0F, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h04, 0, 0, 8'h04, 0, 0));
    for (int i = 0; i < 4; i++)
      t4.push_back(mk(0, 0, MODE_UP, 8'h00, 0, 0, 8'h04, 0, 0));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h05, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h03, 0, 0, 8'h03, 0, 0));
    t4.push_back(mk(0, 1, MODE_ROR,  8'h00, 0, 0, 8'h09, 1, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h07, 0, 0, 8'h07, 1, 0));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h08, 1, 0));
    t4.push_back(mk(1, 1, MODE_UP,   8'h00, 0, 0, 8'h09, 0, 0));
    t4.push_back(mk(0, 1, MODE_UP,   8'h00, 0, 0, 8'h0A, 0, 0));
    t4.push_back(mk(0, 1, MODE_LOAD, 8'h0F, 0, 0, 8'h0F, 0, 0));
    t4.push_back(mk(1, 1, MODE_UP,   8'h00, 0, 0, 8'h09, 0, 0));

    foreach (t8[i]) run_vec(1'b0, t8[i], $sformatf("w8 vec%0d", i));
    foreach (t4[i]) run_vec(1'b1, t4[i], $sformatf("w4 vec%0d", i));

    // Full UP wrap from reset: tc must pulse exactly on the all-ones -> 0 edge.
    begin
      logic [7:0] exp8;
      logic [3:0] exp4;
      run_vec(1'b0, mk(1, 1, MODE_UP, 8'h00, 0, 0, 8'h00, 0, 0), "w8 cnt rst");
      exp8 = 8'h00;
      for (int i = 0; i < 256; i++) begin
        run_vec(1'b0, mk(0, 1, MODE_UP, 8'h00, 0, 0, exp8 + 8'h01, 0, exp8 == 8'hFF),
                $sformatf("w8 cnt%0d", i));
        exp8 = exp8 + 8'h01;
      end
      run_vec(1'b1, mk(1, 1, MODE_UP, 8'h00, 0, 0, 8'h09, 0, 0), "w4 cnt rst");
      exp4 = 4'h9;
      for (int i = 0; i < 20; i++) begin
        run_vec(1'b1, mk(0, 1, MODE_UP, 8'h00, 0, 0, {4'h0, exp4 + 4'h1}, 0, exp4 == 4'hF),
                $sformatf("w4 cnt%0d", i));
        exp4 = exp4 + 4'h1;
      end
      // Count down through zero on the 4-bit instance.
      for (int i = 0; i < 20; i++) begin
        run_vec(1'b1, mk(0, 1, MODE_DOWN, 8'h00, 0, 0, {4'h0, exp4 - 4'h1}, 0, exp4 == 4'h0),
                $sformatf("w4 dn%0d", i));
        exp4 = exp4 - 4'h1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_univ_reg_fall_syn
